// File: rtl/ssd_scan.sv
// Multiplexed seven-segment scanner: shadow-registered digits with BCD decode,
// leading-zero blanking, per-digit decimal points and frame-based blinking.
module ssd_scan #(
  parameter int NDIG         = 4,
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [4*NDIG-1:0] digits,
  input  logic [NDIG-1:0]   dp,
  input  logic [NDIG-1:0]   blink,
  input  logic              blank_lz,
  output logic [7:0]        ssd,
  output logic [NDIG-1:0]   ssd_ctl
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NDIG - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [FW-1:0]     frame_q, frame_d;
  logic              phase_q, phase_d;
  logic [4*NDIG-1:0] digits_q, digits_d;
  logic [NDIG-1:0]   dp_q, dp_d;
  logic [NDIG-1:0]   blink_q, blink_d;
  logic              blank_lz_q, blank_lz_d;
  logic [7:0]        ssd_q, ssd_d;
  logic [NDIG-1:0]   ctl_q, ctl_d;

  logic [3:0]        dig_arr [NDIG];
  logic [NDIG-1:0]   lz_blank;
  logic              cnt_end, idx_end, frame_end;

  function automatic logic [7:0] glyph(input logic [3:0] v);
    case (v)
      4'd0:    glyph = 8'b00000011;
      4'd1:    glyph = 8'b10011111;
      4'd2:    glyph = 8'b00100101;
      4'd3:    glyph = 8'b00001101;
      4'd4:    glyph = 8'b10011001;
      4'd5:    glyph = 8'b01001001;
      4'd6:    glyph = 8'b01000001;
      4'd7:    glyph = 8'b00011111;
      4'd8:    glyph = 8'b00000001;
      4'd9:    glyph = 8'b00001001;
      default: glyph = 8'b01110001;
    endcase
  endfunction

  // A digit is lz-blanked when it and every more-significant digit are zero.
  genvar gi;
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_dig
      assign dig_arr[gi] = digits_q[4*gi +: 4];
      assign ctl_d[gi]   = (idx_q != IW'(gi));
      if (gi == 0) begin : g_lsd
        assign lz_blank[gi] = 1'b0;
      end else begin : g_upper
        assign lz_blank[gi] = blank_lz_q && (digits_q[4*NDIG-1:4*gi] == '0);
      end
    end
  endgenerate

  assign cnt_end   = (cnt_q == CNT_LAST);
  assign idx_end   = (idx_q == IDX_LAST);
  assign frame_end = (frame_q == FRAME_LAST);

  always_comb begin
    cnt_d      = cnt_end ? '0 : cnt_q + CW'(1);
    idx_d      = idx_q;
    frame_d    = frame_q;
    phase_d    = phase_q;
    if (cnt_end) begin
      idx_d = idx_end ? '0 : idx_q + IW'(1);
      if (idx_end) begin
        frame_d = frame_end ? '0 : frame_q + FW'(1);
        if (frame_end) phase_d = ~phase_q;
      end
    end
    digits_d   = load ? digits   : digits_q;
    dp_d       = load ? dp       : dp_q;
    blink_d    = load ? blink    : blink_q;
    blank_lz_d = load ? blank_lz : blank_lz_q;
  end

  // Blink-off wins outright; otherwise lz-blank replaces segments and dp goes on last.
  always_comb begin
    ssd_d = glyph(dig_arr[idx_q]);
    if (lz_blank[idx_q]) ssd_d[7:1] = 7'h7F;
    ssd_d[0] = ~dp_q[idx_q];
    if (phase_q && blink_q[idx_q]) ssd_d = 8'hFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      frame_q    <= '0;
      phase_q    <= 1'b0;
      digits_q   <= '0;
      dp_q       <= '0;
      blink_q    <= '0;
      blank_lz_q <= 1'b0;
      ssd_q      <= 8'hFF;
      ctl_q      <= '1;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      frame_q    <= frame_d;
      phase_q    <= phase_d;
      digits_q   <= digits_d;
      dp_q       <= dp_d;
      blink_q    <= blink_d;
      blank_lz_q <= blank_lz_d;
      ssd_q      <= ssd_d;
      ctl_q      <= ctl_d;
    end
  end

  assign ssd     = ssd_q;
  assign ssd_ctl = ctl_q;

endmodule

// File: tb/tb_ssd_scan.sv
// Self-checking bench for ssd_scan: directed table, hand sequences and random
// loads/resets compared against a time-indexed reference model.
module tb_ssd_scan;
  localparam int ND = 4;
  localparam int SD = 4;
  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  blink = '0;
  logic        blank_lz = 1'b0;
  logic [7:0]  ssd;
  logic [3:0]  ssd_ctl;

  ssd_scan #(.NDIG(ND), .SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .load(load), .digits(digits), .dp(dp),
    .blink(blink), .blank_lz(blank_lz), .ssd(ssd), .ssd_ctl(ssd_ctl)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: cycles since reset plus the currently loaded shadow values.
  int          n;
  logic [15:0] m_d;
  logic [3:0]  m_dp, m_bl;
  logic        m_blz;
  logic [7:0]  glyph_tab [16];

  typedef struct {
    logic [15:0] d;
    logic [3:0]  dpv;
    logic        blz;
    int          pos;
    logic [7:0]  exp;
  } vec_t;
  vec_t vt [10];

  function automatic logic [7:0] ref_ssd(input int nn);
    int          k  = (nn / SD) % ND;
    int          ph = ((nn / (SD * ND)) / BF) % 2;
    logic [15:0] up = m_d >> (4 * k);
    logic [7:0]  g;
    if (ph == 1 && m_bl[k]) return 8'hFF;
    g = glyph_tab[up[3:0]];
    if (m_blz && k >= 1 && up == 16'h0) g = 8'hFF;
    if (m_dp[k]) g[0] = 1'b0;
    return g;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (model cycle %0d)", name, act, exp, n);
    end
  endtask

  task automatic tick(input logic r, input logic ld, input logic [15:0] d,
                      input logic [3:0] dv, input logic [3:0] bv, input logic zv);
    logic [7:0] es;
    logic [3:0] ec;
    rst = r; load = ld; digits = d; dp = dv; blink = bv; blank_lz = zv;
    if (r) begin
      es = 8'hFF; ec = 4'hF;
      m_d = '0; m_dp = '0; m_bl = '0; m_blz = 1'b0; n = 0;
    end else begin
      es = ref_ssd(n);
      ec = 4'hF;
      ec[(n / SD) % ND] = 1'b0;
      n++;
      if (ld) begin m_d = d; m_dp = dv; m_bl = bv; m_blz = zv; end
    end
    @(posedge clk);
    #1;
    check("model_ssd", ssd, es);
    check("model_ctl", {4'h0, ssd_ctl}, {4'h0, ec});
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 16'hFFFF, 4'hF, 4'hF, 1'b1);
  endtask

  initial begin
    bit found;
    logic [3:0] want;
    glyph_tab[0] = 8'b00000011; glyph_tab[1] = 8'b10011111;
    glyph_tab[2] = 8'b00100101; glyph_tab[3] = 8'b00001101;
    glyph_tab[4] = 8'b10011001; glyph_tab[5] = 8'b01001001;
    glyph_tab[6] = 8'b01000001; glyph_tab[7] = 8'b00011111;
    glyph_tab[8] = 8'b00000001; glyph_tab[9] = 8'b00001001;
    for (int i = 10; i < 16; i++) glyph_tab[i] = 8'b01110001;

    vt[0] = '{16'h1234, 4'b0000, 1'b0, 0, 8'b10011001};
    vt[1] = '{16'h1234, 4'b0000, 1'b0, 1, 8'b00001101};
    vt[2] = '{16'h1234, 4'b0000, 1'b0, 2, 8'b00100101};
    vt[3] = '{16'h1234, 4'b0000, 1'b0, 3, 8'b10011111};
    vt[4] = '{16'h0070, 4'b0000, 1'b1, 3, 8'b11111111};
    vt[5] = '{16'h0070, 4'b0000, 1'b1, 2, 8'b11111111};
    vt[6] = '{16'h0070, 4'b0000, 1'b1, 1, 8'b00011111};
    vt[7] = '{16'h0070, 4'b0000, 1'b1, 0, 8'b00000011};
    vt[8] = '{16'h000A, 4'b0001, 1'b0, 0, 8'b01110000};
    vt[9] = '{16'h0000, 4'b0100, 1'b1, 2, 8'b11111110};

    // Reset release: cleared outputs, then digit 0 showing a zero glyph.
    tick(1'b1, 1'b0, '0, '0, '0, 1'b0);
    tick(1'b1, 1'b0, '0, '0, '0, 1'b0);
    check("rst_ssd", ssd, 8'hFF);
    check("rst_ctl", {4'h0, ssd_ctl}, 8'h0F);
    idle();
    check("first_ssd", ssd, 8'b00000011);
    check("first_ctl", {4'h0, ssd_ctl}, 8'h0E);
    $display("[TB] reset release: ssd=%b ctl=%b", ssd, ssd_ctl);

    // Directed table: load, then wait for the target digit slot.
    for (int v = 0; v < 10; v++) begin
      tick(1'b1, 1'b0, '0, '0, '0, 1'b0);
      tick(1'b0, 1'b1, vt[v].d, vt[v].dpv, 4'h0, vt[v].blz);
      idle();
      want = 4'hF;
      want[vt[v].pos] = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
        if (ssd_ctl == want) found = 1'b1;
        else idle();
      end
      if (!found) begin
        n_tests++; n_fail++;
        $display("FAIL vec%0d_timeout: ctl=%b never reached %b", v, ssd_ctl, want);
      end else begin
        check($sformatf("vec%0d_ssd", v), ssd, vt[v].exp);
      end
      $display("[TB] vec %0d digits=%h pos=%0d ssd=%b", v, vt[v].d, vt[v].pos, ssd);
    end

    // Scan order and 16-cycle wrap after loading 1234.
    tick(1'b1, 1'b0, '0, '0, '0, 1'b0);
    tick(1'b0, 1'b1, 16'h1234, 4'h0, 4'h0, 1'b0);
    for (int c = 1; c <= 16; c++) begin
      idle();
      if (c == 12) begin
        check("seq_d3_ctl", {4'h0, ssd_ctl}, 8'h07);
        check("seq_d3_ssd", ssd, 8'b10011111);
      end
    end
    check("seq_wrap_ctl", {4'h0, ssd_ctl}, 8'h0E);
    check("seq_wrap_ssd", ssd, 8'b10011001);
    $display("[TB] scan wrap: ctl=%b ssd=%b", ssd_ctl, ssd);

    // Blink: digit 1 on in frames 0-1, off in frames 2-3, on again in 4.
    tick(1'b1, 1'b0, '0, '0, '0, 1'b0);
    tick(1'b0, 1'b1, 16'h0050, 4'h0, 4'b0010, 1'b0);
    for (int c = 1; c <= 68; c++) begin
      idle();
      if (c == 4)  check("blink_on0", ssd, 8'b01001001);
      if (c == 36) check("blink_off", ssd, 8'b11111111);
      if (c == 68) check("blink_on1", ssd, 8'b01001001);
    end
    $display("[TB] blink sequence done at cycle %0d", n);

    // Mid-scan reset at idx=2,cnt=1 together with a load that must be dropped.
    tick(1'b1, 1'b0, '0, '0, '0, 1'b0);
    tick(1'b0, 1'b1, 16'h1238, 4'hF, 4'h0, 1'b0);
    for (int c = 1; c < 9; c++) idle();
    tick(1'b1, 1'b1, 16'h9999, 4'hF, 4'h0, 1'b0);
    check("mid_rst_ssd", ssd, 8'hFF);
    check("mid_rst_ctl", {4'h0, ssd_ctl}, 8'h0F);
    idle();
    check("post_rst_ssd", ssd, 8'b00000011);
    check("post_rst_ctl", {4'h0, ssd_ctl}, 8'h0E);
    $display("[TB] mid-scan reset: ssd=%b ctl=%b", ssd, ssd_ctl);

    // Random loads and occasional resets against the model.
    for (int c = 0; c < 3000; c++) begin
      tick(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) == 0),
           16'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
    end
    $display("[TB] random phase done, model cycle %0d", n);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
